// File: rtl/rf_sweep_pkg.sv
// Shared types and helpers for the receptive_field_sweep block.
// Window position counts depend on whether RF_ZERO_PAD_EN is defined.
package rf_sweep_pkg;

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DONE} rf_state_t;

  // Number of window positions along one axis.
  function automatic int rf_num_pos(input int img, input int rf, input int stride, input bit pad);
    if (pad) return (img + stride - 1) / stride;
    return (img - rf) / stride + 1;
  endfunction

endpackage

// File: rtl/rf_pos_gen.sv
// Tap and window-position counters plus image-memory address generation.
// With RF_ZERO_PAD_EN defined, coordinates are signed and out-of-bounds taps are flagged.
module rf_pos_gen
  import rf_sweep_pkg::*;
#(
  parameter int ADDR_BITS  = 16,
  parameter int IMG_HEIGHT = 28,
  parameter int IMG_WIDTH  = 28,
  parameter int RF_HEIGHT  = 5,
  parameter int RF_WIDTH   = 5,
  parameter int STRIDE     = 1,
  parameter int NUM_IMAGES = 2,
  parameter int BASE_ADDR  = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 tap_en,
  input  logic                                 pos_en,
  output logic [$clog2(RF_HEIGHT+1)-1:0]       tap_r,
  output logic [$clog2(RF_WIDTH+1)-1:0]        tap_c,
  output logic [ADDR_BITS-1:0]                 addr,
  output logic                                 in_bounds,
  output logic                                 last_tap,
  output logic                                 last_pos,
  output logic                                 last_img,
  output logic [$clog2(IMG_WIDTH)-1:0]         win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]        win_y,
  output logic [$clog2(NUM_IMAGES+1)-1:0]      img_idx
);

  localparam int TRW     = $clog2(RF_HEIGHT + 1);
  localparam int TCW     = $clog2(RF_WIDTH + 1);
  localparam int IW      = $clog2(NUM_IMAGES + 1);
  localparam int WXW     = $clog2(IMG_WIDTH);
  localparam int WYW     = $clog2(IMG_HEIGHT);
  localparam int IMG_MAX = (IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT;
  localparam int CW      = $clog2(IMG_MAX + RF_WIDTH + RF_HEIGHT + STRIDE) + 1;

`ifdef RF_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
  typedef logic signed [CW-1:0] coord_t;
`else
  localparam bit PAD = 1'b0;
  typedef logic [CW-1:0] coord_t;
`endif

  localparam int NX      = rf_num_pos(IMG_WIDTH, RF_WIDTH, STRIDE, PAD);
  localparam int NY      = rf_num_pos(IMG_HEIGHT, RF_HEIGHT, STRIDE, PAD);
  localparam int X_FIRST = PAD ? -(RF_WIDTH / 2) : 0;
  localparam int Y_FIRST = PAD ? -(RF_HEIGHT / 2) : 0;
  localparam int X_LAST  = X_FIRST + (NX - 1) * STRIDE;
  localparam int Y_LAST  = Y_FIRST + (NY - 1) * STRIDE;

  logic [TRW-1:0] r_q, r_d;
  logic [TCW-1:0] c_q, c_d;
  coord_t         x0_q, x0_d, y0_q, y0_d;
  logic [IW-1:0]  img_q, img_d;
  coord_t         px, py;
  logic [ADDR_BITS-1:0] addr_calc;

  always_comb begin
    r_d      = r_q;
    c_d      = c_q;
    last_tap = (r_q == TRW'(RF_HEIGHT - 1)) && (c_q == TCW'(RF_WIDTH - 1));
    if (tap_en) begin
      if (c_q == TCW'(RF_WIDTH - 1)) begin
        c_d = '0;
        r_d = last_tap ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Raster order: x first, then y, then the next image.
  always_comb begin
    x0_d     = x0_q;
    y0_d     = y0_q;
    img_d    = img_q;
    last_pos = (x0_q == coord_t'(X_LAST)) && (y0_q == coord_t'(Y_LAST));
    last_img = (img_q == IW'(NUM_IMAGES - 1));
    if (pos_en) begin
      if (x0_q == coord_t'(X_LAST)) begin
        x0_d = coord_t'(X_FIRST);
        if (y0_q == coord_t'(Y_LAST)) begin
          y0_d  = coord_t'(Y_FIRST);
          img_d = img_q + 1'b1;
        end else begin
          y0_d = y0_q + coord_t'(STRIDE);
        end
      end else begin
        x0_d = x0_q + coord_t'(STRIDE);
      end
    end
  end

  always_comb begin
    px        = x0_q + coord_t'(c_q);
    py        = y0_q + coord_t'(r_q);
    addr_calc = ADDR_BITS'(BASE_ADDR)
              + ADDR_BITS'(img_q) * ADDR_BITS'(IMG_HEIGHT * IMG_WIDTH)
              + ADDR_BITS'(py) * ADDR_BITS'(IMG_WIDTH)
              + ADDR_BITS'(px);
  end

`ifdef RF_ZERO_PAD_EN
  logic [ADDR_BITS-1:0] addr_hold_q, addr_hold_d;

  // Padding taps keep the bus parked on the last real address.
  always_comb begin
    in_bounds   = !px[CW-1] && (px < coord_t'(IMG_WIDTH)) &&
                  !py[CW-1] && (py < coord_t'(IMG_HEIGHT));
    addr        = in_bounds ? addr_calc : addr_hold_q;
    addr_hold_d = addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_hold_q <= ADDR_BITS'(BASE_ADDR);
    else        addr_hold_q <= addr_hold_d;
  end
`else
  assign in_bounds = 1'b1;
  assign addr      = addr_calc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      c_q   <= '0;
      x0_q  <= coord_t'(X_FIRST);
      y0_q  <= coord_t'(Y_FIRST);
      img_q <= '0;
    end else begin
      r_q   <= r_d;
      c_q   <= c_d;
      x0_q  <= x0_d;
      y0_q  <= y0_d;
      img_q <= img_d;
    end
  end

  assign tap_r   = r_q;
  assign tap_c   = c_q;
  assign win_x   = WXW'(x0_q + coord_t'(RF_WIDTH / 2));
  assign win_y   = WYW'(y0_q + coord_t'(RF_HEIGHT / 2));
  assign img_idx = img_q;

endmodule

// File: rtl/receptive_field_sweep.sv
// Receptive-field sweep: fetches each window pixel by pixel, then offers it on a valid/ready port.
// Optional zero padding around the image is enabled by defining RF_ZERO_PAD_EN.
module receptive_field_sweep
  import rf_sweep_pkg::*;
#(
  parameter int ADDR_BITS  = 16,
  parameter int WORD_BITS  = 8,
  parameter int PIXEL_SIZE = 8,
  parameter int IMG_HEIGHT = 28,
  parameter int IMG_WIDTH  = 28,
  parameter int RF_HEIGHT  = 5,
  parameter int RF_WIDTH   = 5,
  parameter int STRIDE     = 1,
  parameter int NUM_IMAGES = 2,
  parameter int BASE_ADDR  = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  output logic [ADDR_BITS-1:0]                      addr,
  input  logic [WORD_BITS-1:0]                      mem_word,
  output logic [RF_HEIGHT*RF_WIDTH*PIXEL_SIZE-1:0]  rf,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [$clog2(IMG_WIDTH)-1:0]              win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]             win_y,
  output logic [$clog2(NUM_IMAGES+1)-1:0]           img_idx,
  output logic                                      done
);

  logic [RF_HEIGHT-1:0][RF_WIDTH-1:0][PIXEL_SIZE-1:0] rf_q, rf_d;
  rf_state_t state_q, state_d;
  logic out_valid_q, out_valid_d;
  logic done_q, done_d;
  logic tap_en, pos_en;
  logic in_bounds, last_tap, last_pos, last_img;
  logic [$clog2(RF_HEIGHT+1)-1:0] tap_r;
  logic [$clog2(RF_WIDTH+1)-1:0]  tap_c;

  rf_pos_gen #(
    .ADDR_BITS (ADDR_BITS),
    .IMG_HEIGHT(IMG_HEIGHT),
    .IMG_WIDTH (IMG_WIDTH),
    .RF_HEIGHT (RF_HEIGHT),
    .RF_WIDTH  (RF_WIDTH),
    .STRIDE    (STRIDE),
    .NUM_IMAGES(NUM_IMAGES),
    .BASE_ADDR (BASE_ADDR)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .tap_en   (tap_en),
    .pos_en   (pos_en),
    .tap_r    (tap_r),
    .tap_c    (tap_c),
    .addr     (addr),
    .in_bounds(in_bounds),
    .last_tap (last_tap),
    .last_pos (last_pos),
    .last_img (last_img),
    .win_x    (win_x),
    .win_y    (win_y),
    .img_idx  (img_idx)
  );

  // The final handshake parks the position so addr and coordinates stay frozen in DONE.
  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    tap_en      = 1'b0;
    pos_en      = 1'b0;
    case (state_q)
      S_FETCH: begin
        tap_en             = 1'b1;
        rf_d[tap_r][tap_c] = in_bounds ? PIXEL_SIZE'(mem_word) : '0;
        if (last_tap) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_pos && last_img) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            pos_en  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      rf_q        <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign rf        = rf_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_receptive_field_sweep.sv
// Directed bench for receptive_field_sweep: a STRIDE=1 and a STRIDE=3 instance share one clock.
// Expectations follow RF_ZERO_PAD_EN when it is defined.
module tb_receptive_field_sweep;
  import rf_sweep_pkg::*;

`ifdef RF_ZERO_PAD_EN
  localparam bit PAD      = 1'b1;
  localparam int FIRST    = -2;
  localparam int EXP_WIN0 = 0;
  localparam int PER_IMG1 = 784;
  localparam int PER_IMG3 = 100;
  localparam int LAST3    = 27;
  localparam int OFF      = 2;
`else
  localparam bit PAD      = 1'b0;
  localparam int FIRST    = 0;
  localparam int EXP_WIN0 = 2;
  localparam int PER_IMG1 = 576;
  localparam int PER_IMG3 = 64;
  localparam int LAST3    = 23;
  localparam int OFF      = 0;
`endif
  localparam int NX1 = rf_num_pos(28, 5, 1, PAD);
  localparam int NX3 = rf_num_pos(28, 5, 3, PAD);

  logic clk = 1'b0;
  logic rst_n, rst3_n, ready;
  logic ready3 = 1'b1;
  logic [15:0] addr1, addr3;
  logic [7:0] mem1, mem3;
  logic [199:0] rf1, rf3;
  logic valid1, valid3, done1, done3;
  logic [4:0] win_x1, win_y1, win_x3, win_y3;
  logic [1:0] img1, img3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  receptive_field_sweep dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr1), .mem_word(mem1), .rf(rf1),
    .out_valid(valid1), .out_ready(ready), .win_x(win_x1), .win_y(win_y1),
    .img_idx(img1), .done(done1)
  );

  receptive_field_sweep #(.STRIDE(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .addr(addr3), .mem_word(mem3), .rf(rf3),
    .out_valid(valid3), .out_ready(ready3), .win_x(win_x3), .win_y(win_y3),
    .img_idx(img3), .done(done3)
  );

  function automatic logic [7:0] memModel(input logic [15:0] a);
    int v;
    v = int'(a);
    if (v < 784) return 8'(v % 256);
    if (v < 1568) return 8'(255 - ((v - 784) % 256));
    return 8'hA5;
  endfunction

  function automatic logic [7:0] pixModel(input int im, input int y, input int x);
    int v;
    if (y < 0 || y >= 28 || x < 0 || x >= 28) return 8'd0;
    v = (y * 28 + x) % 256;
    return (im == 0) ? 8'(v) : 8'(255 - v);
  endfunction

  function automatic logic [199:0] windowModel(input int im, input int x0, input int y0);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[(r*5+c)*8 +: 8] = pixModel(im, y0 + r, x0 + c);
    return w;
  endfunction

  assign mem1 = memModel(addr1);
  assign mem3 = memModel(addr3);

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard for the STRIDE=1 instance: every accepted window against the pixel model.
  int hs1 = 0;
  int hs1_img0 = 0;
  logic [199:0] first_img1_rf = '0;
  logic [1:0] first_img1_idx = '0;
  always @(negedge clk) begin : mon1
    int k, im, ex0, ey0;
    if (!rst_n) begin
      hs1 = 0;
      hs1_img0 = 0;
    end else if (valid1 && ready) begin
      k   = hs1 % PER_IMG1;
      im  = hs1 / PER_IMG1;
      ex0 = FIRST + (k % NX1);
      ey0 = FIRST + (k / NX1);
      checkOutput("sweep1_rf", 256'(rf1), 256'(windowModel(im, ex0, ey0)));
      checkOutput("sweep1_pos", 256'({img1, win_y1, win_x1}), 256'({2'(im), 5'(ey0 + 2), 5'(ex0 + 2)}));
      if (hs1 == PER_IMG1) begin
        first_img1_rf  = rf1;
        first_img1_idx = img1;
      end
      if (img1 == 2'd0) hs1_img0++;
      hs1++;
    end
  end

  // Scoreboard for the STRIDE=3 instance.
  int hs3 = 0;
  int hs3_img0 = 0;
  int last3_x = 0;
  int last3_y = 0;
  always @(negedge clk) begin : mon3
    int k, im, ex0, ey0;
    if (!rst3_n) begin
      hs3 = 0;
      hs3_img0 = 0;
    end else if (valid3 && ready3) begin
      k   = hs3 % PER_IMG3;
      im  = hs3 / PER_IMG3;
      ex0 = FIRST + (k % NX3) * 3;
      ey0 = FIRST + (k / NX3) * 3;
      checkOutput("sweep3_rf", 256'(rf3), 256'(windowModel(im, ex0, ey0)));
      if (img3 == 2'd0) begin
        hs3_img0++;
        last3_x = int'(win_x3);
        last3_y = int'(win_y3);
      end
      hs3++;
    end
  end

  initial begin
    logic [15:0] ref_addr;
    int n;
    int bad;
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    ready  = 1'b0;
    applyStimulus(3);

    checkOutput("rst_valid", 256'(valid1), 256'(0));
    checkOutput("rst_done", 256'(done1), 256'(0));
    checkOutput("rst_addr", 256'(addr1), 256'(0));
    checkOutput("rst_pos", 256'({img1, win_y1, win_x1}), 256'({2'd0, 5'(EXP_WIN0), 5'(EXP_WIN0)}));
    checkOutput("rst_rf", 256'(rf1), 256'(0));

    rst_n  = 1'b1;
    rst3_n = 1'b1;
    applyStimulus(24);
    checkOutput("lat_valid_24", 256'(valid1), 256'(0));
    applyStimulus(1);
    checkOutput("lat_valid_25", 256'(valid1), 256'(1));
    checkOutput("w0_rf", 256'(rf1), 256'(windowModel(0, FIRST, FIRST)));
    checkOutput("w0_pos", 256'({img1, win_y1, win_x1}), 256'({2'd0, 5'(EXP_WIN0), 5'(EXP_WIN0)}));

    ref_addr = addr1;
    applyStimulus(10);
    checkOutput("hold_valid", 256'(valid1), 256'(1));
    checkOutput("hold_rf", 256'(rf1), 256'(windowModel(0, FIRST, FIRST)));
    checkOutput("hold_addr", 256'(addr1), 256'(ref_addr));
    checkOutput("hold_pos", 256'({img1, win_y1, win_x1}), 256'({2'd0, 5'(EXP_WIN0), 5'(EXP_WIN0)}));

    ready = 1'b1;
    applyStimulus(1);
    checkOutput("hs_valid_drop", 256'(valid1), 256'(0));
    n = 0;
    while (!valid1 && n < 40) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("w1_latency", 256'(n), 256'(25));
    checkOutput("w1_rf", 256'(rf1), 256'(windowModel(0, FIRST + 1, FIRST)));
    checkOutput("w1_pos", 256'({img1, win_y1, win_x1}), 256'({2'd0, 5'(EXP_WIN0), 5'(EXP_WIN0 + 1)}));

    n = 0;
    while (hs1 < 5 && n < 400) begin
      applyStimulus(1);
      n++;
    end
    applyStimulus(10);
    checkOutput("w5_in_fetch", 256'({valid1, 3'(hs1)}), 256'({1'b0, 3'd5}));

    rst_n = 1'b0;
    applyStimulus(1);
    checkOutput("abort_valid", 256'(valid1), 256'(0));
    checkOutput("abort_addr", 256'(addr1), 256'(0));
    checkOutput("abort_rf", 256'(rf1), 256'(0));
    checkOutput("abort_pos", 256'({img1, win_y1, win_x1}), 256'({2'd0, 5'(EXP_WIN0), 5'(EXP_WIN0)}));
    rst_n = 1'b1;

    n = 0;
    while (!valid1 && n < 40) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("restart_latency", 256'(n), 256'(25));
    checkOutput("restart_rf", 256'(rf1), 256'(windowModel(0, FIRST, FIRST)));
    checkOutput("restart_win_x", 256'(win_x1), 256'(EXP_WIN0));

    n = 0;
    while (!done1 && n < 60000) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("done_reached", 256'(done1), 256'(1));
    checkOutput("done_valid", 256'(valid1), 256'(0));
    checkOutput("count_img0", 256'(hs1_img0), 256'(PER_IMG1));
    checkOutput("count_total", 256'(hs1), 256'(2 * PER_IMG1));

    ref_addr = addr1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      ready = (i % 2) == 0;
      applyStimulus(1);
      if (!done1 || valid1) bad++;
    end
    checkOutput("done_stable_cycles", 256'(bad), 256'(0));
    checkOutput("done_addr_held", 256'(addr1), 256'(ref_addr));
    checkOutput("done_count_held", 256'(hs1), 256'(2 * PER_IMG1));

    checkOutput("img1_first_px", 256'(first_img1_rf[(OFF*5+OFF)*8 +: 8]), 256'(255));
    checkOutput("img1_second_row_px", 256'(first_img1_rf[((OFF+1)*5+OFF)*8 +: 8]), 256'(227));
    checkOutput("img1_idx", 256'(first_img1_idx), 256'(1));

    checkOutput("s3_done", 256'(done3), 256'(1));
    checkOutput("s3_count_img0", 256'(hs3_img0), 256'(PER_IMG3));
    checkOutput("s3_count_total", 256'(hs3), 256'(2 * PER_IMG3));
    checkOutput("s3_last_win", 256'({last3_y[4:0], last3_x[4:0]}), 256'({5'(LAST3), 5'(LAST3)}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
